dcache_direct_wb: RTL and testbench
===================================

# dcache_direct_wb

Direct-mapped, write-back, write-allocate data cache between the CHIP core's data port and the `slow_memD` instance of `slow_memory`. It answers 32-bit word requests from the core in zero stall cycles on a hit. On a miss it issues 128-bit block transfers over the slow-memory handshake: `mem_read`/`mem_write`, `mem_addr[31:4]`, and `mem_ready`. The core's `memory_stall` output is driven from this block's `proc_stall`.

## Interface
Parameters:
- `LINES`, 8: number of cache lines (power of two). Index width `IW = log2(LINES)`.
- `TW`, 28−IW (25 at default): tag width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `proc_read`  in  1  core read request, level-held while `proc_stall`=1.
- `proc_write`  in  1  core write request, level-held while `proc_stall`=1.
- `proc_addr`  in  30  word address: `[1:0]` word offset, `[IW+1:2]` index, `[29:IW+2]` tag.
- `proc_wdata`  in  32  write data.
- `proc_rdata`  out  32  read data (combinational).
- `proc_stall`  out  1  core must hold its request while high (combinational).
- `mem_read`  out  1  block read request to slow memory.
- `mem_write`  out  1  block write request to slow memory.
- `mem_addr`  out  28  block address, bits [31:4].
- `mem_wdata`  out  128  victim block; word 0 sits in [31:0].
- `mem_rdata`  in  128  fill block; word 0 sits in [31:0].
- `mem_ready`  in  1  one-cycle pulse that completes the current memory transaction.

## Operation
Storage:
- Per line: `valid`, `dirty`, tag[TW], data[128].

States:
- COMPARE (reset state).
- WRITEBACK.
- ALLOCATE.

COMPARE:
- A request is active when `proc_read` or `proc_write` is high. If both are high, the request is a write.
- hit = valid[idx] && tag[idx]==addr tag.
- Read hit: `proc_rdata` = selected word, `proc_stall`=0.
- Write hit: the selected word takes `proc_wdata` at the edge, dirty[idx] sets to 1, and `proc_stall`=0.
- Miss on a dirty line: `proc_stall`=1 and the next state is WRITEBACK.
- Miss on a clean or invalid line: `proc_stall`=1 and the next state is ALLOCATE.
- No request: `proc_stall`=0 and nothing changes.

WRITEBACK:
- Outputs: `mem_write`=1, `mem_addr`={tag[idx], idx}, `mem_wdata`=data[idx].
- On `mem_ready`, the next state is ALLOCATE.

ALLOCATE:
- Outputs: `mem_read`=1, `mem_addr`={req tag, idx}.
- On `mem_ready`, at the same edge: data[idx] ← `mem_rdata`, tag ← req tag, valid=1, dirty=0, next state COMPARE.

After a fill:
- In COMPARE the request now hits and completes as a normal hit.
- A write merges into the freshly filled line and sets dirty.

General rules:
- `proc_stall`=1 in WRITEBACK and ALLOCATE regardless of the request inputs.
- `mem_read` and `mem_write` are never high together.
- `mem_addr` and `mem_wdata` are stable while a request is high.
- `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are decoded from registered state only: no combinational path from `proc_*`.
- `proc_rdata` outside a read hit equals the selected word of the indexed line; it is not checked.

## Timing
- Hit: zero stall cycles. Write data is visible to a read of the same word in the next cycle.
- Clean miss:
  - cycle 0: request, `proc_stall`=1.
  - cycle 1: `mem_read`=1, held until the `mem_ready` cycle R.
  - cycle R+1: COMPARE, hit, `proc_stall`=0.
- Dirty miss: WRITEBACK from cycle 1 to the ready cycle W, then ALLOCATE from W+1 to R, then a hit at R+1.
- `mem_read` and `mem_write` drop in the cycle after `mem_ready`.
- `mem_ready` seen in COMPARE is ignored.
- Reset (`rst_n`=0 at an edge), at any time including mid-transfer:
  - next state COMPARE.
  - all valid and dirty bits cleared; dirty data is discarded.
  - `mem_read`=`mem_write`=0 from the following cycle.
  - tags and data are not reset.
- Output values after reset: `mem_read`=0, `mem_write`=0, `proc_stall`=0 unless a request is presented (a request then misses).

## Test plan
1. Reset, then read `proc_addr`=0x00000004 with memory block 0x0000001 = {0x44,0x33,0x22,0x11} -> `mem_read` with `mem_addr`=0x0000001; after ready, stall drops at R+1 and `proc_rdata`=0x11.
2. Write 0xDEADBEEF to 0x00000005 (line already filled), then read 0x00000005 -> no stall on either access; read returns 0xDEADBEEF and dirty[1]=1.
3. Read 0x00000025 (same index 1, tag 1) after scenario 2 -> `mem_write` with `mem_addr`=0x0000001 and `mem_wdata` word1=0xDEADBEEF; then `mem_read` with `mem_addr`=0x0000009; then a hit.
4. Write miss to a clean line at 0x00000042 with data 0xCAFEF00D -> ALLOCATE only (no `mem_write`); the filled line has word2=0xCAFEF00D and dirty=1.
5. Assert `rst_n`=0 while in ALLOCATE with `mem_read`=1 -> `mem_read`=0 in the next cycle; a read of the previously valid 0x00000004 misses again.
6. Assert `proc_read` and `proc_write` together on a hit -> the write is performed, dirty sets, and `proc_stall`=0.

Source files
------------

// File: rtl/dcache_direct_wb_if.sv
// Core-side and memory-side buses of the direct-mapped write-back data cache.
// slave: the cache's view; master: the core plus slow-memory environment.
interface dcache_direct_wb_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits complete with no stall; misses move 128-bit blocks over the slow-memory
// handshake, writing back a dirty victim before the fill.
module dcache_direct_wb #(
    parameter int LINES = 8,
    parameter int TW    = 28 - $clog2(LINES)
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_direct_wb_if.slave  bus
);
    localparam int IW = $clog2(LINES);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;

    state_e           state_q, state_d;
    logic [LINES-1:0] valid_q, dirty_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [127:0]     data_q [LINES];
    // Missing request address, so memory-side outputs depend on registers only.
    logic [29:0]      req_addr_q;

    logic [IW-1:0] idx, req_idx;
    logic [TW-1:0] tag, req_tag;
    logic [1:0]    off;
    logic          req_active, hit, miss, write_hit;

    assign idx       = bus.proc_addr[IW+1:2];
    assign tag       = bus.proc_addr[29:IW+2];
    assign off       = bus.proc_addr[1:0];
    assign req_idx   = req_addr_q[IW+1:2];
    assign req_tag   = req_addr_q[29:IW+2];

    assign req_active = bus.proc_read | bus.proc_write;
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign miss       = (state_q == COMPARE) && req_active && !hit;
    // A simultaneous read and write is treated as a write.
    assign write_hit  = (state_q == COMPARE) && bus.proc_write && hit;

    // State register with synchronous reset back to COMPARE.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= COMPARE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COMPARE:   if (miss) state_d = dirty_q[idx] ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (bus.mem_ready) state_d = ALLOCATE;
            ALLOCATE:  if (bus.mem_ready) state_d = COMPARE;
            default:   state_d = COMPARE;
        endcase
    end

    // Output decode; memory-side outputs use only registered state.
    always_comb begin
        bus.proc_rdata = data_q[idx][{off, 5'd0} +: 32];
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = {req_tag, req_idx};
        bus.mem_wdata  = data_q[req_idx];
        unique case (state_q)
            COMPARE:   bus.proc_stall = req_active && !hit;
            WRITEBACK: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {tag_q[req_idx], req_idx};
            end
            ALLOCATE:  bus.mem_read = 1'b1;
            default:   bus.proc_stall = 1'b1;
        endcase
    end

    // Capture the request address when a miss leaves COMPARE.
    always_ff @(posedge clk) begin
        if (miss) req_addr_q <= bus.proc_addr;
    end

    // Tag and data arrays: block fill on allocate completion, word merge on write hit.
    always_ff @(posedge clk) begin
        if (state_q == ALLOCATE && bus.mem_ready) begin
            data_q[req_idx] <= bus.mem_rdata;
            tag_q[req_idx]  <= req_tag;
        end else if (write_hit) begin
            data_q[idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
        end
    end

    // Valid and dirty bits; cleared by reset, discarding any dirty data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == ALLOCATE && bus.mem_ready) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Self-checking bench for dcache_direct_wb: a flat golden word memory predicts
// read data, an expected-transaction queue predicts slow-memory traffic.
module tb_dcache_direct_wb;
    localparam int LAT = 3;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } memtx_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   overlap  = 0;
    int   wait_cnt = 0;

    memtx_t       mq[$];
    logic [31:0]  rd_q[$];
    logic [31:0]  gold [logic [29:0]];
    logic [127:0] bmem [logic [27:0]];

    dcache_direct_wb_if mif ();

    dcache_direct_wb #(.LINES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        logic [127:0] blk1;
        blk1 = 128'h00000044_00000033_00000022_00000011;
        if (a[29:2] == 28'h1) return blk1[{a[1:0], 5'd0} +: 32];
        return 32'h5A00_0000 ^ {2'b00, a};
    endfunction

    function automatic logic [31:0] gword(input logic [29:0] a);
        if (gold.exists(a)) return gold[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] gblock(input logic [27:0] b);
        return {gword({b, 2'd3}), gword({b, 2'd2}), gword({b, 2'd1}), gword({b, 2'd0})};
    endfunction

    function automatic logic [127:0] init_block(input logic [27:0] b);
        return {init_word({b, 2'd3}), init_word({b, 2'd2}), init_word({b, 2'd1}), init_word({b, 2'd0})};
    endfunction

    task automatic exp_rd(input logic [27:0] b);
        memtx_t t;
        t.wr = 1'b0; t.addr = b; t.wdata = '0;
        mq.push_back(t);
    endtask

    task automatic exp_wb(input logic [27:0] b);
        memtx_t t;
        t.wr = 1'b1; t.addr = b; t.wdata = gblock(b);
        mq.push_back(t);
    endtask

    // Slow memory: answers each request LAT+1 cycles after it appears.
    initial begin
        memtx_t t;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mif.mem_ready = 1'b0;
            if (mif.mem_read && mif.mem_write) overlap++;
            if (rst_n && (mif.mem_read || mif.mem_write)) begin
                if (wait_cnt == LAT) begin
                    wait_cnt = 0;
                    mif.mem_ready = 1'b1;
                    if (mq.size() == 0) begin
                        check("mem_unexpected", 128'd1, '0);
                    end else begin
                        t = mq.pop_front();
                        check("mem_dir", 128'(mif.mem_write), 128'(t.wr));
                        check("mem_addr", 128'(mif.mem_addr), 128'(t.addr));
                        if (t.wr) check("mem_wdata", mif.mem_wdata, t.wdata);
                    end
                    if (mif.mem_write) bmem[mif.mem_addr] = mif.mem_wdata;
                    else mif.mem_rdata = bmem.exists(mif.mem_addr) ? bmem[mif.mem_addr]
                                                                   : init_block(mif.mem_addr);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cpu_access(input string tag, input logic rd, input logic wr,
                              input logic [29:0] a, input logic [31:0] wd, input int exp_stalls);
        int stalls;
        logic [31:0] exp;
        @(negedge clk);
        mif.proc_read  = rd;
        mif.proc_write = wr;
        mif.proc_addr  = a;
        mif.proc_wdata = wd;
        if (wr) gold[a] = wd;
        else    rd_q.push_back(gword(a));
        stalls = 0;
        #1;
        while (mif.proc_stall && stalls < 60) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, ":stall_cycles"}, 128'(stalls), 128'(exp_stalls));
        check({tag, ":mem_idle"}, 128'({mif.mem_read, mif.mem_write}), '0);
        if (!wr) begin
            exp = rd_q.pop_front();
            check({tag, ":rdata"}, 128'(mif.proc_rdata), 128'(exp));
        end
        @(posedge clk);
        #1;
        mif.proc_read  = 1'b0;
        mif.proc_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        mif.proc_read  = 1'b0;
        mif.proc_write = 1'b0;
        mif.proc_addr  = '0;
        mif.proc_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst:stall", 128'(mif.proc_stall), '0);
        check("rst:mem_read", 128'(mif.mem_read), '0);
        check("rst:mem_write", 128'(mif.mem_write), '0);

        // Clean read miss then fill.
        exp_rd(28'h1);
        cpu_access("s1_read", 1'b1, 1'b0, 30'h4, '0, LAT + 2);

        // Write hit, then read back.
        cpu_access("s2_write", 1'b0, 1'b1, 30'h5, 32'hDEADBEEF, 0);
        cpu_access("s2_read", 1'b1, 1'b0, 30'h5, '0, 0);

        // Conflict miss on dirty line 1: writeback then fill.
        exp_wb(28'h1);
        exp_rd(28'h9);
        cpu_access("s3_read", 1'b1, 1'b0, 30'h25, '0, 2 * LAT + 3);

        // Write miss on invalid line 0: fill only, then merge.
        exp_rd(28'h10);
        cpu_access("s4_write", 1'b0, 1'b1, 30'h42, 32'hCAFEF00D, LAT + 2);
        cpu_access("s4_read", 1'b1, 1'b0, 30'h42, '0, 0);
        exp_wb(28'h10);
        exp_rd(28'h0);
        cpu_access("s4_evict", 1'b1, 1'b0, 30'h02, '0, 2 * LAT + 3);

        // Highest index line.
        exp_rd(28'h7);
        cpu_access("s7_write", 1'b0, 1'b1, 30'h1F, 32'h0BADF00D, LAT + 2);
        exp_wb(28'h7);
        exp_rd(28'hF);
        cpu_access("s7_evict", 1'b1, 1'b0, 30'h3F, '0, 2 * LAT + 3);

        // Reset while allocating.
        @(negedge clk);
        mif.proc_read = 1'b1;
        mif.proc_addr = 30'h84;
        #1;
        check("s5:miss_stall", 128'(mif.proc_stall), 128'd1);
        @(negedge clk);
        #1;
        check("s5:alloc_read", 128'(mif.mem_read), 128'd1);
        check("s5:alloc_nowb", 128'(mif.mem_write), '0);
        rst_n         = 1'b0;
        mif.proc_read = 1'b0;
        @(negedge clk);
        #1;
        check("s5:read_dropped", 128'(mif.mem_read), '0);
        check("s5:write_low", 128'(mif.mem_write), '0);
        check("s5:stall_low", 128'(mif.proc_stall), '0);
        rst_n = 1'b1;
        exp_rd(28'h9);
        cpu_access("s5_remiss", 1'b1, 1'b0, 30'h25, '0, LAT + 2);

        // Read and write together on a hit: the write wins and dirties the line.
        cpu_access("s6_rw", 1'b1, 1'b1, 30'h25, 32'h12345678, 0);
        cpu_access("s6_read", 1'b1, 1'b0, 30'h25, '0, 0);
        exp_wb(28'h9);
        exp_rd(28'h1);
        cpu_access("s6_evict", 1'b1, 1'b0, 30'h05, '0, 2 * LAT + 3);

        repeat (2) @(negedge clk);
        check("mem_exclusive", 128'(overlap), '0);
        check("memq_drained", 128'(mq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
